// File: rtl/vga_pkg.sv
// Shared VGA draw-chain definitions used by the text overlay stage.
package vga_pkg;

   // Text box geometry: 16 columns x 8 rows of 8x16 pixel glyphs.
   localparam int TXT_COLS = 16;
   localparam int TXT_ROWS = 8;
   localparam int CHAR_W   = 8;
   localparam int CHAR_H   = 16;

   localparam int TXT_BOX_W = TXT_COLS * CHAR_W;
   localparam int TXT_BOX_H = TXT_ROWS * CHAR_H;

   // Input-to-output latency of the text overlay stage, in pixel clocks.
   localparam int TXT_PIPE_LAT = 5;

   // VGA timing bundle carried alongside the pixel colour.
   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
   } vga_timing_t;

endpackage

// File: rtl/delay_line.sv
// Fixed-length register chain; clears to zero on reset.
module delay_line #(
   parameter int WIDTH   = 8,
   parameter int CLK_DEL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [CLK_DEL-1:0][WIDTH-1:0] pipe_reg;

   // Shift the input one stage per clock; reset empties the whole chain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_reg <= '0;
      end else begin
         for (int i = CLK_DEL - 1; i > 0; i--) begin
            pipe_reg[i] <= pipe_reg[i-1];
         end
         pipe_reg[0] <= din;
      end
   end

   assign dout = pipe_reg[CLK_DEL-1];

endmodule

// File: rtl/game_text_render.sv
// Text box overlay: addresses the text ROM and font ROM from the pixel
// position and paints set glyph pixels over the incoming RGB stream.
module game_text_render
   import vga_pkg::*;
#(
   parameter logic [10:0] XPOS   = 11'd256,
   parameter logic [10:0] YPOS   = 11'd200,
   parameter logic [11:0] FG_RGB = 12'hFFF,
   parameter int          BOX_W  = TXT_BOX_W,
   parameter int          BOX_H  = TXT_BOX_H
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   output logic [7:0]  char_xy,
   input  logic [6:0]  char_code,
   output logic [10:0] font_addr,
   input  logic [7:0]  font_data,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   // Box edges widened to 12 bits so XPOS+BOX_W cannot wrap.
   localparam logic [11:0] X_LO = {1'b0, XPOS};
   localparam logic [11:0] X_HI = X_LO + 12'(BOX_W);
   localparam logic [11:0] Y_LO = {1'b0, YPOS};
   localparam logic [11:0] Y_HI = Y_LO + 12'(BOX_H);

   // Sideband carried to the output stage: in_box, pixel-in-glyph, colour.
   localparam int SIDE_W = 1 + 3 + 12;

   logic [6:0]        rx;
   logic [6:0]        ry;
   logic              in_box;
   logic [11:0]       h_ext;
   logic [11:0]       v_ext;
   vga_timing_t       timing_in;
   vga_timing_t       timing_out;
   logic [SIDE_W-1:0] side_in;
   logic [SIDE_W-1:0] side_s4;
   logic              in_box_s4;
   logic [2:0]        bit_idx_s4;
   logic [11:0]       rgb_s4;
   logic [3:0]        line_s2;

   // Only the low 7 bits of the box-relative offsets address a cell, and
   // those bits of the difference depend only on the low operand bits.
   assign rx    = hcount_in[6:0] - XPOS[6:0];
   assign ry    = vcount_in[6:0] - YPOS[6:0];
   assign h_ext = {1'b0, hcount_in};
   assign v_ext = {1'b0, vcount_in};

   assign in_box = en & ~hblnk_in & ~vblnk_in
                 & (h_ext >= X_LO) & (h_ext < X_HI)
                 & (v_ext >= Y_LO) & (v_ext < Y_HI);

   // Cell address to the text ROM; pixels outside the box point at cell 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         char_xy <= 8'h00;
      end else begin
         char_xy <= in_box ? {1'b0, ry[6:4], rx[6:3]} : 8'h00;
      end
   end

   assign timing_in = '{hcount: hcount_in, vcount: vcount_in,
                        hsync: hsync_in, vsync: vsync_in,
                        hblnk: hblnk_in, vblnk: vblnk_in};

   // Timing goes straight to the outputs through the full pipeline depth.
   delay_line #(
      .WIDTH   ($bits(vga_timing_t)),
      .CLK_DEL (TXT_PIPE_LAT)
   ) u_timing_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (timing_in),
      .dout (timing_out)
   );

   assign side_in = {in_box, rx[2:0], rgb_in};

   // Overlay sideband reaches the last stage one clock before the outputs.
   delay_line #(
      .WIDTH   (SIDE_W),
      .CLK_DEL (TXT_PIPE_LAT - 1)
   ) u_side_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (side_in),
      .dout (side_s4)
   );

   assign {in_box_s4, bit_idx_s4, rgb_s4} = side_s4;

   // Glyph line must line up with char_code, which lands two clocks in.
   delay_line #(
      .WIDTH   (4),
      .CLK_DEL (2)
   ) u_line_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (ry[3:0]),
      .dout (line_s2)
   );

   // Font ROM address from the returned character and its glyph line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         font_addr <= 11'h000;
      end else begin
         font_addr <= {char_code, line_s2};
      end
   end

   // Paint the foreground colour where the glyph bit is set inside the box.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rgb_out <= 12'h000;
      end else begin
         rgb_out <= (in_box_s4 & font_data[3'd7 - bit_idx_s4]) ? FG_RGB : rgb_s4;
      end
   end

   assign hcount_out = timing_out.hcount;
   assign vcount_out = timing_out.vcount;
   assign hsync_out  = timing_out.hsync;
   assign vsync_out  = timing_out.vsync;
   assign hblnk_out  = timing_out.hblnk;
   assign vblnk_out  = timing_out.vblnk;

endmodule

// File: tb/tb_game_text_render.sv
// Self-checking bench for game_text_render with behavioural text/font ROMs.
module tb_game_text_render;

   localparam int XP = 256;
   localparam int YP = 200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [10:0] hcount_in = '0;
   logic [10:0] vcount_in = '0;
   logic        hsync_in = 1'b0;
   logic        vsync_in = 1'b0;
   logic        hblnk_in = 1'b0;
   logic        vblnk_in = 1'b0;
   logic [11:0] rgb_in = '0;
   logic [7:0]  char_xy;
   logic [6:0]  char_code;
   logic [10:0] font_addr;
   logic [7:0]  font_data;
   logic [10:0] hcount_out;
   logic [10:0] vcount_out;
   logic        hsync_out;
   logic        vsync_out;
   logic        hblnk_out;
   logic        vblnk_out;
   logic [11:0] rgb_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] text_mem [256];
   logic [7:0] font_mem [2048];

   typedef struct {
      bit valid;
      int h;
      int v;
      bit en;
      bit hs;
      bit vs;
      bit hb;
      bit vb;
      int rgb;
   } pix_t;

   pix_t hist [6];

   game_text_render dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .hcount_in  (hcount_in),
      .vcount_in  (vcount_in),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .hblnk_in   (hblnk_in),
      .vblnk_in   (vblnk_in),
      .rgb_in     (rgb_in),
      .char_xy    (char_xy),
      .char_code  (char_code),
      .font_addr  (font_addr),
      .font_data  (font_data),
      .hcount_out (hcount_out),
      .vcount_out (vcount_out),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out),
      .hblnk_out  (hblnk_out),
      .vblnk_out  (vblnk_out),
      .rgb_out    (rgb_out)
   );

   always #5 clk = ~clk;

   // One-cycle registered ROMs.
   always @(posedge clk) begin
      char_code <= text_mem[char_xy];
      font_data <= font_mem[font_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit inside_box(input pix_t p);
      return p.en && !p.hb && !p.vb && p.h >= XP && p.h < XP + 128
             && p.v >= YP && p.v < YP + 128;
   endfunction

   function automatic int exp_cxy(input pix_t p);
      if (!inside_box(p)) return 0;
      return ((p.v - YP) / 16) * 16 + (p.h - XP) / 8;
   endfunction

   function automatic int exp_faddr(input pix_t p);
      if (!p.valid) return 0;
      return int'(text_mem[exp_cxy(p)]) * 16 + ((p.v - YP) & 15);
   endfunction

   function automatic int exp_rgb(input pix_t p);
      logic [7:0] g;
      int px;
      if (!inside_box(p)) return p.rgb;
      px = (p.h - XP) % 8;
      g  = font_mem[int'(text_mem[exp_cxy(p)]) * 16 + (p.v - YP) % 16];
      if (g[7 - px]) return 'hFFF;
      return p.rgb;
   endfunction

   // Model: remember what the DUT sampled on each edge; reset forgets it all.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 6; i++) hist[i] <= '{default: 0};
      end else begin
         for (int i = 5; i > 1; i--) hist[i] <= hist[i-1];
         hist[1] <= '{valid: 1'b1, h: int'(hcount_in), v: int'(vcount_in), en: en,
                      hs: hsync_in, vs: vsync_in, hb: hblnk_in, vb: vblnk_in,
                      rgb: int'(rgb_in)};
      end
   end

   // Compare every cycle, shortly after the active edge.
   always @(posedge clk) begin
      #1;
      chk("cxy", 32'(char_xy), 32'(exp_cxy(hist[1])));
      chk("faddr", 32'(font_addr), 32'(exp_faddr(hist[3])));
      chk("rgb", 32'(rgb_out), 32'(exp_rgb(hist[5])));
      chk("hcnt", 32'(hcount_out), 32'(hist[5].h));
      chk("vcnt", 32'(vcount_out), 32'(hist[5].v));
      chk("tsig", {28'd0, hsync_out, vsync_out, hblnk_out, vblnk_out},
          {28'd0, hist[5].hs, hist[5].vs, hist[5].hb, hist[5].vb});
   end

   task automatic set_in(input int h, input int v, input bit e, input bit hb,
                         input bit vb, input int c);
      hcount_in = 11'(h);
      vcount_in = 11'(v);
      en        = e;
      hblnk_in  = hb;
      vblnk_in  = vb;
      hsync_in  = h[2];
      vsync_in  = v[1];
      rgb_in    = 12'(c);
   endtask

   task automatic drive(input int h, input int v, input bit e, input bit hb,
                        input bit vb, input int c);
      @(negedge clk);
      set_in(h, v, e, hb, vb, c);
   endtask

   // Hold one pixel until it has fully crossed the pipeline, then pin it.
   task automatic vec(input string nm, input int h, input int v, input bit e,
                      input bit hb, input bit vb, input int c,
                      input int want_rgb, input int want_cxy);
      drive(h, v, e, hb, vb, c);
      repeat (5) @(posedge clk);
      #1;
      chk({nm, "_rgb"}, 32'(rgb_out), 32'(want_rgb));
      chk({nm, "_cxy"}, 32'(char_xy), 32'(want_cxy));
      $display("vec %s h=%0d v=%0d rgb_out=%03h char_xy=%02h", nm, h, v, rgb_out, char_xy);
   endtask

   task automatic stream(input int v, input int h0, input int h1);
      for (int h = h0; h <= h1; h++) begin
         drive(h, v, ((h / 13) % 4) != 0, h > 388, 1'b0, (h * 29 + v) & 'hFFF);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) text_mem[i] = 7'((i * 5 + 1) % 128);
      text_mem[0]    = 7'h00;
      text_mem[8'h65] = 7'h31;
      text_mem[8'h6F] = 7'h41;
      text_mem[8'h05] = 7'h22;
      text_mem[8'h75] = 7'h22;
      for (int i = 0; i < 2048; i++) font_mem[i] = 8'((i * 73) ^ (i >> 3));
      for (int l = 0; l < 16; l++) begin
         font_mem[16'h41 * 16 + l] = 8'hFF;
         font_mem[16'h22 * 16 + l] = 8'hFF;
      end
      font_mem[11'h312] = 8'b0001_0000;

      // Reset with random inputs.
      #2 rst = 1'b0;
      #1;
      chk("rst_now_rgb", 32'(rgb_out), 32'h0);
      repeat (4) drive($urandom_range(0, 2047), $urandom_range(0, 2047), 1'($urandom),
                       1'($urandom), 1'($urandom), $urandom_range(0, 4095));
      @(posedge clk); #1;
      chk("rst_cxy", 32'(char_xy), 32'h00);
      chk("rst_faddr", 32'(font_addr), 32'h000);
      chk("rst_rgb", 32'(rgb_out), 32'h000);
      chk("rst_hcnt", 32'(hcount_out), 32'h000);

      // Release together with the cell-addressing pixel; watch each edge.
      @(negedge clk);
      rst = 1'b1;
      set_in(XP + 43, YP + 98, 1'b1, 1'b0, 1'b0, 'h123);
      @(posedge clk); #1;
      chk("cell_cxy", 32'(char_xy), 32'h65);
      repeat (2) @(posedge clk);
      #1;
      chk("cell_faddr", 32'(font_addr), 32'h312);
      @(posedge clk); #1;
      chk("lat_rgb_e4", 32'(rgb_out), 32'h000);
      @(posedge clk); #1;
      chk("ovl_rgb_e5", 32'(rgb_out), 32'hFFF);
      chk("lat_hcnt_e5", 32'(hcount_out), 32'(XP + 43));
      $display("vec cell h=%0d v=%0d char_xy=65 font_addr=312 rgb_out=%03h", XP + 43, YP + 98, rgb_out);

      vec("ovl_next", XP + 44, YP + 98, 1'b1, 1'b0, 1'b0, 'h123, 'h123, 'h65);
      vec("x_last",  XP + 127, YP + 98, 1'b1, 1'b0, 1'b0, 'h456, 'hFFF, 'h6F);
      vec("x_out",   XP + 128, YP + 98, 1'b1, 1'b0, 1'b0, 'h456, 'h456, 'h00);
      vec("y_before", XP + 43, YP - 1,  1'b1, 1'b0, 1'b0, 'h456, 'h456, 'h00);
      vec("y_first", XP + 43, YP,       1'b1, 1'b0, 1'b0, 'h456, 'hFFF, 'h05);
      vec("y_last",  XP + 43, YP + 127, 1'b1, 1'b0, 1'b0, 'h456, 'hFFF, 'h75);
      vec("y_out",   XP + 43, YP + 128, 1'b1, 1'b0, 1'b0, 'h456, 'h456, 'h00);
      vec("hblnk",   XP + 127, YP + 98, 1'b1, 1'b1, 1'b0, 'hABC, 'hABC, 'h00);
      vec("vblnk",   XP + 127, YP + 98, 1'b1, 1'b0, 1'b1, 'hABC, 'hABC, 'h00);
      vec("en_off",  XP + 127, YP + 98, 1'b0, 1'b0, 1'b0, 'hABC, 'hABC, 'h00);
      chk("blank_hcnt", 32'(hcount_out), 32'(XP + 127));
      chk("blank_vcnt", 32'(vcount_out), 32'(YP + 98));

      // Streaming pixels across the box edges with en toggling mid-line.
      stream(YP + 98, XP - 8, XP + 136);
      stream(YP - 1, XP - 6, XP + 9);
      stream(YP, XP - 6, XP + 9);
      stream(YP + 127, XP + 122, XP + 134);
      stream(YP + 128, XP + 122, XP + 134);

      // Mid-frame reset during active overlay.
      stream(YP + 98, XP + 40, XP + 56);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_rgb", 32'(rgb_out), 32'h000);
      chk("mrst_cxy", 32'(char_xy), 32'h00);
      chk("mrst_faddr", 32'(font_addr), 32'h000);
      chk("mrst_vcnt", 32'(vcount_out), 32'h000);
      $display("vec midreset rgb_out=%03h char_xy=%02h", rgb_out, char_xy);
      stream(YP + 98, XP + 57, XP + 58);
      @(negedge clk);
      rst = 1'b1;
      stream(YP + 98, XP + 40, XP + 60);

      repeat (6) @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/game_text_render.md
Name: game_text_render

Overview:
- Downstream consumer of the game text-content ROMs (char_xy -> char_code, 1-cycle registered lookup).
- Maps the current VGA pixel to a character cell of a 16x8 text box and drives char_xy to the selected content ROM.
- Forms the font-ROM address from the returned char_code plus the glyph line, and overlays the glyph pixel onto the incoming RGB stream.
- Sits in the VGA draw chain between the background/sprite stages and the output register; all timing signals are delayed to stay aligned with the modified RGB.

Parameters:
- XPOS, 11'd256: left pixel column of the text box.
- YPOS, 11'd200: top pixel row of the text box.
- FG_RGB, 12'hFFF: colour driven for set glyph pixels.
- BOX_W, 128: box width in pixels (16 cols x 8 px). Fixed by the char_xy format; not to be overridden.
- BOX_H, 128: box height in pixels (8 rows x 16 px). Fixed by the char_xy format; not to be overridden.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  text overlay enable; sampled with the pixel.
- hcount_in  in  11  pixel column.
- vcount_in  in  11  pixel line.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing.
- rgb_in  in  12  upstream colour.
- char_xy  out  8  {row[3:0], col[3:0]} to the text ROM.
- char_code  in  7  text ROM data, valid 1 cycle after char_xy.
- font_addr  out  11  {char_code, glyph_line[3:0]} to the font ROM.
- font_data  in  8  font ROM row, valid 1 cycle after font_addr; bit 7 is the leftmost pixel.
- hcount_out, vcount_out  out  11  delayed hcount/vcount.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing.
- rgb_out  out  12  overlaid colour.

Behaviour:
- Reset (rst=0, asynchronous): every output and every pipeline register is 0, including char_xy and font_addr. Deassertion is taken on the next clk edge.
- Stage 0 (combinational on the inputs):
  - rx = hcount_in - XPOS, ry = vcount_in - YPOS, computed in 12 bits.
  - in_box = en & ~hblnk_in & ~vblnk_in & (hcount_in >= XPOS) & (hcount_in < XPOS+128) & (vcount_in >= YPOS) & (vcount_in < YPOS+128).
- Edge 1:
  - char_xy <= in_box ? {1'b0, ry[6:4], rx[6:3]} : 8'h00.
  - Stage-1 register captures in_box, bit_idx = rx[2:0], line = ry[3:0], timing and rgb.
- Edge 2: the text ROM presents char_code. Stage 2 copies the stage-1 sideband.
- Edge 3: font_addr <= {char_code, line_s2}. Stage 3 copies the sideband.
- Edge 4: the font ROM presents font_data. Stage 4 copies the sideband.
- Edge 5 (output):
  - rgb_out <= (in_box_s4 & font_data[7 - bit_idx_s4]) ? FG_RGB : rgb_s4.
  - All timing outputs take their stage-4 values.
- Total latency from inputs to outputs: exactly 5 clk cycles, for every signal, regardless of in_box.
- Pipeline runs every cycle; there is no stall or handshake.
- Outside the box, during blanking, or with en=0: rgb_out equals rgb_in delayed by 5 cycles, bit-exact.
- Box boundaries:
  - Columns XPOS and XPOS+127 are inside; XPOS+128 is outside.
  - Lines YPOS and YPOS+127 are inside; YPOS+128 is outside.
  - XPOS+128 must not exceed 2047; unsigned compare in 12 bits, no wrap.
- en toggling mid-line takes effect per pixel, 5 cycles later at the output.
- Reset mid-frame: pipeline flushes to 0 immediately. Outputs are 0 until 5 edges after release, then track the inputs again; no stale pixels.
- ROM latency contract: the text ROM and the font ROM are each exactly 1 cycle. Any other latency is an integration error; no runtime detection is required.

Decomposition:
- vga_pkg gains:
  - TXT_COLS=16, TXT_ROWS=8, CHAR_W=8, CHAR_H=16.
  - Derived TXT_BOX_W/H.
  - TXT_PIPE_LAT=5.
- One natural sub-module: delay_line (params WIDTH, CLK_DEL; async active-low reset to 0). Used for the timing/rgb/sideband bundle so alignment is by construction.
- The text ROM and font ROM stay external; the integrating top connects char_xy/char_code and font_addr/font_data.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0, char_xy=8'h00, font_addr=11'h000. Release -> outputs follow the inputs after 5 edges.
- Cell addressing: hcount=XPOS+43 (col 5, bit 3), vcount=YPOS+98 (row 6, line 2), en=1 -> char_xy=8'h65 after edge 1. With model ROM returning 7'h31 -> font_addr=11'h312 after edge 3.
- Overlay: same pixel, font_data=8'b0001_0000 (bit 4 = pixel index 3 set), rgb_in=12'h123 -> rgb_out=12'hFFF at edge 5. Next pixel (index 4) -> rgb_out=12'h123.
- Boundaries: hcount=XPOS+127 vs XPOS+128, and vcount=YPOS-1 vs YPOS, with font_data=8'hFF -> overlay only at inside coordinates; char_xy=8'h00 outside.
- Blank/enable: hblnk=1 or en=0, font_data=8'hFF, rgb_in=12'hABC -> rgb_out=12'hABC. All timing outputs equal the inputs delayed exactly 5 cycles.
- Mid-frame reset: pulse rst low for 3 cycles during active overlay -> outputs 0 immediately. No FG pixel appears in the first 5 cycles after release unless in_box holds for the new pixels.
